// File: rtl/sa_result_drain_if.sv
// Result-row stream between the systolic-array drain and its consumer.
// The drain drives one requantised row per valid/ready beat.
interface sa_result_drain_if #(
  parameter int D_W = 8,
  parameter int X_R = 16,
  parameter int W_C = 16
) ();

  localparam int IDX_W = $clog2(X_R);

  logic                      valid;
  logic                      ready;
  logic [W_C-1:0][D_W-1:0]   row;
  logic [IDX_W-1:0]          row_idx;
  logic                      last;

  modport master (
    output valid,
    output row,
    output row_idx,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  row,
    input  row_idx,
    input  last,
    output ready
  );

endinterface

// File: rtl/sa_result_drain.sv
// Systolic-array result drain: waits out the array skew after a tile, snapshots
// the accumulator grid, clears the array, then streams requantised rows
// (round-half-up, arithmetic shift, saturate) one per handshake.
module sa_result_drain #(
  parameter int D_W   = 8,
  parameter int ACC_W = 24,
  parameter int X_R   = 16,
  parameter int W_C   = 16
) (
  input  logic                                I_CLK,
  input  logic                                I_ASYN_RSTN,
  input  logic                                I_SYNC_RSTN,
  input  logic                                I_START,
  input  logic                                I_PE_SHIFT,
  input  logic [4:0]                          I_FRAC_SHIFT,
  input  logic [X_R-1:0][W_C-1:0][ACC_W-1:0]  I_ACC,
  output logic                                O_SA_CLR,
  output logic                                O_BUSY,
  output logic                                O_DONE,
  sa_result_drain_if.master                   rd
);

  localparam int IDX_W   = $clog2(X_R);
  localparam int FLUSH_N = X_R + W_C - 2;
  localparam int CNT_W   = $clog2(FLUSH_N + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(X_R - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_N - 1);

  // Saturation bounds in the widened (ACC_W+1) domain; the low bound is the
  // two's-complement partner of the high bound.
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (D_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                             state;
  state_t                             state_n;
  logic [CNT_W-1:0]                   flush_cnt;
  logic [IDX_W-1:0]                   row_idx;
  logic [4:0]                         shift_q;
  logic [X_R-1:0][W_C-1:0][ACC_W-1:0] snap;
  logic [W_C-1:0][D_W-1:0]            row_out;
  logic                               send_fire;

  // Round half up, arithmetic shift, saturate; the extra bit keeps the
  // rounding add from overflowing.
  function automatic logic [D_W-1:0] requant(input logic [ACC_W-1:0] acc,
                                             input logic [4:0]       s);
    logic        [ACC_W:0] rnd;
    logic signed [ACC_W:0] v;
    rnd = '0;
    if (s != 5'd0) rnd = (ACC_W+1)'(1) << (s - 5'd1);
    v = $signed({acc[ACC_W-1], acc} + rnd);
    v = v >>> s;
    if (v > SAT_HI)      return SAT_HI[D_W-1:0];
    else if (v < SAT_LO) return SAT_LO[D_W-1:0];
    else                 return v[D_W-1:0];
  endfunction

  assign send_fire = (state == S_SEND) && rd.ready;

  // State register; the synchronous reset is honoured on the clock edge.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN)      state <= S_IDLE;
    else if (!I_SYNC_RSTN) state <= S_IDLE;
    else                   state <= state_n;
  end

  // Next-state decode and per-state control pulses.
  always_comb begin
    state_n  = state;
    O_SA_CLR = 1'b0;
    O_DONE   = 1'b0;
    O_BUSY   = (state != S_IDLE);
    case (state)
      S_IDLE:  if (I_START) state_n = S_FLUSH;
      S_FLUSH: if (I_PE_SHIFT && (flush_cnt == LAST_FLUSH)) state_n = S_CAPT;
      S_CAPT: begin
        O_SA_CLR = 1'b1;
        state_n  = S_SEND;
      end
      S_SEND:  if (send_fire && (row_idx == LAST_IDX)) state_n = S_DONE;
      S_DONE: begin
        O_DONE  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath registers: shift sample, skew counter, grid snapshot, row pointer.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      flush_cnt <= '0;
      row_idx   <= '0;
      shift_q   <= '0;
      snap      <= '0;
    end else if (!I_SYNC_RSTN) begin
      flush_cnt <= '0;
      row_idx   <= '0;
      shift_q   <= '0;
      snap      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (I_START) begin
            shift_q   <= I_FRAC_SHIFT;
            flush_cnt <= '0;
          end
        end
        S_FLUSH: if (I_PE_SHIFT) flush_cnt <= flush_cnt + CNT_W'(1);
        S_CAPT: begin
          snap    <= I_ACC;
          row_idx <= '0;
        end
        S_SEND: if (send_fire && (row_idx != LAST_IDX)) row_idx <= row_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // Output row is requantised straight from the snapshot and forced to zero
  // whenever no row is being offered.
  always_comb begin
    row_out = '0;
    for (int c = 0; c < W_C; c++) begin
      row_out[c] = requant(snap[row_idx][c], shift_q);
    end
    rd.valid   = (state == S_SEND);
    rd.row     = rd.valid ? row_out : '0;
    rd.row_idx = rd.valid ? row_idx : '0;
    rd.last    = rd.valid && (row_idx == LAST_IDX);
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: stimulus pushes expected rows,
// a negedge monitor pops and compares on every accepted beat.
module tb_sa_result_drain;

  localparam int D_W   = 8;
  localparam int ACC_W = 24;
  localparam int X_R   = 16;
  localparam int W_C   = 16;

  typedef logic [X_R-1:0][W_C-1:0][ACC_W-1:0] grid_t;

  typedef struct {
    logic [3:0]   idx;
    logic         last;
    logic [127:0] row;
  } exp_t;

  logic        I_CLK = 1'b0;
  logic        I_ASYN_RSTN;
  logic        I_SYNC_RSTN;
  logic        I_START;
  logic        I_PE_SHIFT;
  logic [4:0]  I_FRAC_SHIFT;
  grid_t       I_ACC;
  logic        O_SA_CLR;
  logic        O_BUSY;
  logic        O_DONE;

  sa_result_drain_if #(.D_W(D_W), .X_R(X_R), .W_C(W_C)) rd ();

  sa_result_drain #(.D_W(D_W), .ACC_W(ACC_W), .X_R(X_R), .W_C(W_C)) dut (
    .I_CLK        (I_CLK),
    .I_ASYN_RSTN  (I_ASYN_RSTN),
    .I_SYNC_RSTN  (I_SYNC_RSTN),
    .I_START      (I_START),
    .I_PE_SHIFT   (I_PE_SHIFT),
    .I_FRAC_SHIFT (I_FRAC_SHIFT),
    .I_ACC        (I_ACC),
    .O_SA_CLR     (O_SA_CLR),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE),
    .rd           (rd)
  );

  always #5 I_CLK = ~I_CLK;

  exp_t exp_q[$];
  int   vec_cnt    = 0;
  int   err_cnt    = 0;
  int   sa_clr_cnt = 0;
  int   done_cnt   = 0;
  int   rows_acc   = 0;
  int   ready_mode = 0;
  int   pe_mode    = 0;
  int   test_id    = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference requantiser built on floor division rather than shifting.
  function automatic logic [7:0] refRequant(input logic [23:0] acc, input int s);
    longint a, d, v, q;
    a = longint'($signed(acc));
    d = longint'(1) << s;
    v = a + ((s > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  function automatic logic [127:0] refRow(input grid_t g, input int r, input int s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < W_C; c++) res[c*8 +: 8] = refRequant(g[r][c], s);
    return res;
  endfunction

  task automatic pushTile(input grid_t g, input int s);
    for (int r = 0; r < X_R; r++) exp_q.push_back('{4'(r), (r == X_R - 1), refRow(g, r, s)});
  endtask

  task automatic pushRow0(input logic [127:0] r0);
    exp_q.push_back('{4'(0), 1'b0, r0});
    for (int r = 1; r < X_R; r++) exp_q.push_back('{4'(r), (r == X_R - 1), 128'(0)});
  endtask

  task automatic startTile(input logic [4:0] s);
    @(posedge I_CLK); #1;
    I_FRAC_SHIFT = s;
    I_START      = 1'b1;
    @(posedge I_CLK); #1;
    I_START      = 1'b0;
    I_FRAC_SHIFT = 5'd7;
  endtask

  // Runs one tile end to end and checks capture timing and completion.
  task automatic applyStimulus(input logic [4:0] s, input int clr_cycle_exp,
                               input bit swap_acc, input bit start_mid);
    int cyc, strobes, d0, cl;
    d0 = done_cnt;
    startTile(s);
    cyc = 1;
    strobes = 0;
    while (cyc < 400) begin
      @(negedge I_CLK);
      if (O_SA_CLR) break;
      if (I_PE_SHIFT) strobes++;
      I_START = start_mid && (strobes == 10);
      cyc++;
    end
    I_START = 1'b0;
    checkOutput("sa_clr_seen", O_SA_CLR, 1'b1);
    if (clr_cycle_exp > 0) checkOutput("sa_clr_cycle", cyc, clr_cycle_exp);
    checkOutput("flush_strobes", strobes, X_R + W_C - 2);
    if (swap_acc) begin
      @(posedge I_CLK); #1;
      for (int r = 0; r < X_R; r++)
        for (int c = 0; c < W_C; c++) I_ACC[r][c] = 24'h000100;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 400) begin
      @(negedge I_CLK);
      I_START = start_mid && (cyc == 3);
      cyc++;
    end
    I_START = 1'b0;
    cl = sa_clr_cnt;
    repeat (40) @(negedge I_CLK);
    checkOutput("done_pulses", done_cnt - d0, 1);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("busy_after", O_BUSY, 1'b0);
    checkOutput("no_extra_tile", sa_clr_cnt, cl);
  endtask

  // Input drivers for the advance strobe and consumer ready.
  initial begin
    int pc, rc;
    pc = 0;
    rc = 0;
    I_PE_SHIFT = 1'b1;
    rd.ready   = 1'b1;
    forever begin
      @(posedge I_CLK); #1;
      I_PE_SHIFT = (pe_mode == 0) ? 1'b1 : ((pc % 3) == 0);
      rd.ready   = (ready_mode == 0) ? 1'b1 : (((rc % 4) == 0) || ((rc % 4) == 3));
      pc++;
      rc++;
    end
  end

  // Monitor: scoreboard pops, stall stability, pulse counting.
  initial begin
    logic         prev_stall;
    logic [127:0] prev_row;
    logic [3:0]   prev_idx;
    exp_t         e;
    prev_stall = 1'b0;
    prev_row   = '0;
    prev_idx   = '0;
    forever begin
      @(negedge I_CLK);
      if (!I_ASYN_RSTN) begin
        prev_stall = 1'b0;
        continue;
      end
      if (O_SA_CLR) sa_clr_cnt++;
      if (O_DONE) begin
        done_cnt++;
        checkOutput("valid_low_at_done", rd.valid, 1'b0);
      end
      if (prev_stall) begin
        checkOutput("stall_valid", rd.valid, 1'b1);
        checkOutput("stall_row", rd.row, prev_row);
        checkOutput("stall_idx", rd.row_idx, prev_idx);
      end
      if (rd.valid && rd.ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("row_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("row_idx", rd.row_idx, e.idx);
          checkOutput("row_last", rd.last, e.last);
          checkOutput("row_data", rd.row, e.row);
          if (test_id == 1 && rd.row_idx == 4'd7) checkOutput("row7_col3", rd.row[3], 8'd115);
          rows_acc++;
        end
      end
      prev_stall = rd.valid && !rd.ready;
      prev_row   = rd.row;
      prev_idx   = rd.row_idx;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    grid_t        g;
    logic [127:0] r0;
    int           d0, n, cl;

    I_ASYN_RSTN  = 1'b0;
    I_SYNC_RSTN  = 1'b1;
    I_START      = 1'b0;
    I_FRAC_SHIFT = 5'd0;
    I_ACC        = '0;
    #12;
    checkOutput("rst_valid", rd.valid, 1'b0);
    checkOutput("rst_busy", O_BUSY, 1'b0);
    checkOutput("rst_sa_clr", O_SA_CLR, 1'b0);
    checkOutput("rst_done", O_DONE, 1'b0);
    checkOutput("rst_row", rd.row, 128'(0));
    checkOutput("rst_idx", rd.row_idx, 4'd0);
    checkOutput("rst_last", rd.last, 1'b0);
    @(negedge I_CLK);
    I_ASYN_RSTN = 1'b1;

    $display("[TB] test 1: ramp grid, shift 0");
    test_id = 1;
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++) g[r][c] = 24'(r * 16 + c);
    I_ACC = g;
    pushTile(g, 0);
    applyStimulus(5'd0, 31, 1'b0, 1'b0);
    checkOutput("rows_tile1", rows_acc, 16);
    test_id = 0;

    $display("[TB] test 2: requant corner values");
    g = '0;
    g[0][0] = 24'd40;
    g[0][1] = 24'hFFFFD8;
    g[0][2] = 24'd24;
    g[0][3] = 24'hFFFFE8;
    I_ACC = g;
    r0 = '0;
    r0[7:0] = 8'h03; r0[15:8] = 8'hFE; r0[23:16] = 8'h02; r0[31:24] = 8'hFF;
    pushRow0(r0);
    applyStimulus(5'd4, 31, 1'b0, 1'b0);
    g = '0;
    g[0][0] = 24'd100000;
    g[0][1] = 24'hFE7960;
    I_ACC = g;
    r0 = '0;
    r0[7:0] = 8'h7F; r0[15:8] = 8'h80;
    pushRow0(r0);
    applyStimulus(5'd0, 31, 1'b0, 1'b0);
    g = '0;
    g[0][0] = 24'h7FFFFF;
    g[0][1] = 24'h800000;
    I_ACC = g;
    r0 = '0;
    r0[7:0] = 8'h01; r0[15:8] = 8'hFF;
    pushRow0(r0);
    applyStimulus(5'd23, 31, 1'b0, 1'b0);

    $display("[TB] test 3: backpressure 1,0,0,1");
    ready_mode = 1;
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++) g[r][c] = 24'(r * 300 - c * 77 - 2000);
    I_ACC = g;
    n = rows_acc;
    pushTile(g, 3);
    applyStimulus(5'd3, 31, 1'b0, 1'b0);
    checkOutput("rows_backpressure", rows_acc - n, 16);
    ready_mode = 0;

    $display("[TB] test 4: snapshot isolation");
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++) g[r][c] = 24'(r * c * 5 - 300);
    I_ACC = g;
    pushTile(g, 1);
    applyStimulus(5'd1, 31, 1'b1, 1'b0);

    $display("[TB] test 5: sparse strobes, ignored starts");
    pe_mode = 1;
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++) g[r][c] = 24'(r * 16 + c);
    I_ACC = g;
    n = rows_acc;
    pushTile(g, 0);
    applyStimulus(5'd0, 0, 1'b0, 1'b1);
    checkOutput("rows_one_tile", rows_acc - n, 16);
    pe_mode = 0;

    $display("[TB] test 6: async reset mid-send");
    pushTile(g, 0);
    d0 = done_cnt;
    startTile(5'd0);
    n = 0;
    while (!(rd.valid && rd.row_idx == 4'd5) && n < 200) begin
      @(negedge I_CLK);
      n++;
    end
    checkOutput("reached_row5", rd.row_idx, 4'd5);
    #2;
    I_ASYN_RSTN = 1'b0;
    #1;
    checkOutput("arst_valid", rd.valid, 1'b0);
    checkOutput("arst_busy", O_BUSY, 1'b0);
    checkOutput("arst_row", rd.row, 128'(0));
    exp_q.delete();
    @(negedge I_CLK);
    @(negedge I_CLK);
    I_ASYN_RSTN = 1'b1;
    repeat (5) @(negedge I_CLK);
    checkOutput("arst_no_done", done_cnt, d0);
    pushTile(g, 0);
    applyStimulus(5'd0, 31, 1'b0, 1'b0);

    $display("[TB] test 7: sync reset mid-flush");
    cl = sa_clr_cnt;
    startTile(5'd0);
    repeat (5) @(negedge I_CLK);
    checkOutput("srst_busy_before", O_BUSY, 1'b1);
    I_SYNC_RSTN = 1'b0;
    @(negedge I_CLK);
    checkOutput("srst_busy_after", O_BUSY, 1'b0);
    I_SYNC_RSTN = 1'b1;
    repeat (40) @(negedge I_CLK);
    checkOutput("srst_no_capture", sa_clr_cnt, cl);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
